// File: rtl/rpc_phy_tx.sv
// rpc_phy_tx: RPC DRAM transmit sequencer; command word plus write burst to registered pad signals.
// Optional macro RPC_PHY_TX_PULLDOWN_EN drives pad pull-downs on undriven lines, else tied low.
module rpc_phy_tx #(
  parameter int PRE_CYCLES = 2,
  parameter int LEN_W      = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_i,
  input  logic             cmd_wr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [15:0]      wdata_i,
  output logic             busy_o,
  output logic             out_clk_o,
  output logic             out_clkn_o,
  output logic             out_stb_o,
  output logic             out_csn_o,
  output logic [15:0]      out_db_o,
  output logic             out_dqs_o,
  output logic             out_dqsn_o,
  output logic             oe_db_o,
  output logic             oe_dqs_o,
  output logic             ie_db_o,
  output logic             ie_dqs_o,
  output logic             pd_en_db_o,
  output logic             pd_en_dqs_o
);

  // state     | meaning
  // IDLE      | pads parked, accepting commands
  // CSN_SETUP | csn asserted ahead of the command
  // CMD0/CMD1 | upper / lower command half on DB with STB high
  // PRE       | DQS write preamble, PRE_CYCLES long
  // WDATA     | one beat per handshake, clk/dqs toggle per beat
  // POST      | final clk edge after the last beat
  // CSN_HOLD  | csn released, pads parked
  typedef enum logic [2:0] {
    IDLE, CSN_SETUP, CMD0, CMD1, PRE, WDATA, POST, CSN_HOLD
  } state_e;

  localparam int PRE_W = (PRE_CYCLES > 1) ? $clog2(PRE_CYCLES) : 1;

  state_e           state_q, state_d;
  logic [31:0]      cmd_q, cmd_d;
  logic             wr_q, wr_d;
  logic [LEN_W-1:0] len_q, len_d, beat_q, beat_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic             csn_q, csn_d, stb_q, stb_d, clk_q, clk_d, dqs_q, dqs_d;
  logic             oe_db_q, oe_db_d, oe_dqs_q, oe_dqs_d;
  logic [15:0]      db_q, db_d;
  logic             clkn_q, dqsn_q, ie_db_q, ie_dqs_q;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    wr_d     = wr_q;
    len_d    = len_q;
    beat_d   = beat_q;
    pre_d    = pre_q;
    csn_d    = csn_q;
    stb_d    = stb_q;
    clk_d    = clk_q;
    dqs_d    = dqs_q;
    db_d     = db_q;
    oe_db_d  = oe_db_q;
    oe_dqs_d = oe_dqs_q;
    case (state_q)
      IDLE: begin
        csn_d    = 1'b1;
        stb_d    = 1'b0;
        clk_d    = 1'b0;
        dqs_d    = 1'b0;
        db_d     = '0;
        oe_db_d  = 1'b0;
        oe_dqs_d = 1'b0;
        if (cmd_valid_i) begin
          cmd_d   = cmd_i;
          wr_d    = cmd_wr_i;
          len_d   = cmd_len_i;
          beat_d  = '0;
          state_d = CSN_SETUP;
        end
      end
      CSN_SETUP: begin
        csn_d   = 1'b0;
        clk_d   = 1'b0;
        state_d = CMD0;
      end
      CMD0: begin
        db_d    = cmd_q[31:16];
        stb_d   = 1'b1;
        oe_db_d = 1'b1;
        clk_d   = 1'b1;
        state_d = CMD1;
      end
      CMD1: begin
        db_d    = cmd_q[15:0];
        stb_d   = 1'b1;
        clk_d   = 1'b0;
        pre_d   = PRE_W'(PRE_CYCLES - 1);
        state_d = wr_q ? PRE : CSN_HOLD;
      end
      PRE: begin
        stb_d    = 1'b0;
        oe_dqs_d = 1'b1;
        dqs_d    = 1'b0;
        db_d     = '0;
        clk_d    = ~clk_q;
        if (pre_q == '0) state_d = WDATA;
        else             pre_d   = pre_q - 1'b1;
      end
      WDATA: begin
        // Without a beat the pads freeze, so the DRAM sees a stretched clock.
        if (wdata_valid_i) begin
          db_d   = wdata_i;
          dqs_d  = ~dqs_q;
          clk_d  = ~clk_q;
          beat_d = beat_q + 1'b1;
          if (beat_q == len_q) state_d = POST;
        end
      end
      POST: begin
        clk_d   = ~clk_q;
        state_d = CSN_HOLD;
      end
      CSN_HOLD: begin
        csn_d    = 1'b1;
        stb_d    = 1'b0;
        clk_d    = 1'b0;
        dqs_d    = 1'b0;
        db_d     = '0;
        oe_db_d  = 1'b0;
        oe_dqs_d = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      wr_q     <= 1'b0;
      len_q    <= '0;
      beat_q   <= '0;
      pre_q    <= '0;
      csn_q    <= 1'b1;
      stb_q    <= 1'b0;
      clk_q    <= 1'b0;
      clkn_q   <= 1'b1;
      dqs_q    <= 1'b0;
      dqsn_q   <= 1'b1;
      db_q     <= '0;
      oe_db_q  <= 1'b0;
      oe_dqs_q <= 1'b0;
      ie_db_q  <= 1'b1;
      ie_dqs_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      wr_q     <= wr_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      pre_q    <= pre_d;
      csn_q    <= csn_d;
      stb_q    <= stb_d;
      clk_q    <= clk_d;
      clkn_q   <= ~clk_d;
      dqs_q    <= dqs_d;
      dqsn_q   <= ~dqs_d;
      db_q     <= db_d;
      oe_db_q  <= oe_db_d;
      oe_dqs_q <= oe_dqs_d;
      ie_db_q  <= ~oe_db_d;
      ie_dqs_q <= ~oe_dqs_d;
    end
  end

`ifdef RPC_PHY_TX_PULLDOWN_EN
  logic pd_db_q, pd_dqs_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pd_db_q  <= 1'b1;
      pd_dqs_q <= 1'b1;
    end else begin
      pd_db_q  <= ~oe_db_d;
      pd_dqs_q <= ~oe_dqs_d;
    end
  end

  assign pd_en_db_o  = pd_db_q;
  assign pd_en_dqs_o = pd_dqs_q;
`else
  assign pd_en_db_o  = 1'b0;
  assign pd_en_dqs_o = 1'b0;
`endif

  assign cmd_ready_o   = (state_q == IDLE);
  assign wdata_ready_o = (state_q == WDATA);
  assign busy_o        = (state_q != IDLE);
  assign out_clk_o     = clk_q;
  assign out_clkn_o    = clkn_q;
  assign out_stb_o     = stb_q;
  assign out_csn_o     = csn_q;
  assign out_db_o      = db_q;
  assign out_dqs_o     = dqs_q;
  assign out_dqsn_o    = dqsn_q;
  assign oe_db_o       = oe_db_q;
  assign oe_dqs_o      = oe_dqs_q;
  assign ie_db_o       = ie_db_q;
  assign ie_dqs_o      = ie_dqs_q;

endmodule

// File: tb/tb_rpc_phy_tx.sv
// Bench for rpc_phy_tx: per-cycle expected pad state is queued with the stimulus and
// compared one cycle at a time after each rising edge.
module tb_rpc_phy_tx;
  localparam int PRE = 2;
  localparam int LW  = 6;

  typedef struct packed {
    logic          csn, stb, clk, clkn;
    logic [15:0]   db;
    logic          dqs, dqsn, oe_db, oe_dqs, ie_db, ie_dqs, pd_db, pd_dqs;
    logic          cmd_ready, wdata_ready, busy;
  } pins_t;

  typedef struct packed {
    logic          cv, cw;
    logic [LW-1:0] len;
    logic [31:0]   cmd;
    logic          wv;
    logic [15:0]   wd;
  } stim_t;

  logic          clk_i, rst_ni;
  logic          cmd_valid_i, cmd_ready_o, cmd_wr_i;
  logic [31:0]   cmd_i;
  logic [LW-1:0] cmd_len_i;
  logic          wdata_valid_i, wdata_ready_o, busy_o;
  logic [15:0]   wdata_i, out_db_o;
  logic          out_clk_o, out_clkn_o, out_stb_o, out_csn_o, out_dqs_o, out_dqsn_o;
  logic          oe_db_o, oe_dqs_o, ie_db_o, ie_dqs_o, pd_en_db_o, pd_en_dqs_o;

  int    nerr = 0;
  int    nchk = 0;
  stim_t sq[$];
  pins_t eq[$];

  rpc_phy_tx #(.PRE_CYCLES(PRE), .LEN_W(LW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_i(cmd_i),
    .cmd_wr_i(cmd_wr_i), .cmd_len_i(cmd_len_i),
    .wdata_valid_i(wdata_valid_i), .wdata_ready_o(wdata_ready_o), .wdata_i(wdata_i),
    .busy_o(busy_o),
    .out_clk_o(out_clk_o), .out_clkn_o(out_clkn_o), .out_stb_o(out_stb_o),
    .out_csn_o(out_csn_o), .out_db_o(out_db_o),
    .out_dqs_o(out_dqs_o), .out_dqsn_o(out_dqsn_o),
    .oe_db_o(oe_db_o), .oe_dqs_o(oe_dqs_o), .ie_db_o(ie_db_o), .ie_dqs_o(ie_dqs_o),
    .pd_en_db_o(pd_en_db_o), .pd_en_dqs_o(pd_en_dqs_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic pins_t mk(input logic csn, stb, clk, input logic [15:0] db,
                               input logic dqs, oe_db, oe_dqs, cr, wr, busy);
    pins_t p;
    p.csn = csn; p.stb = stb; p.clk = clk; p.clkn = ~clk;
    p.db = db; p.dqs = dqs; p.dqsn = ~dqs;
    p.oe_db = oe_db; p.oe_dqs = oe_dqs; p.ie_db = ~oe_db; p.ie_dqs = ~oe_dqs;
`ifdef RPC_PHY_TX_PULLDOWN_EN
    p.pd_db = ~oe_db; p.pd_dqs = ~oe_dqs;
`else
    p.pd_db = 1'b0; p.pd_dqs = 1'b0;
`endif
    p.cmd_ready = cr; p.wdata_ready = wr; p.busy = busy;
    return p;
  endfunction

  function automatic pins_t sample();
    pins_t p;
    p.csn = out_csn_o; p.stb = out_stb_o; p.clk = out_clk_o; p.clkn = out_clkn_o;
    p.db = out_db_o; p.dqs = out_dqs_o; p.dqsn = out_dqsn_o;
    p.oe_db = oe_db_o; p.oe_dqs = oe_dqs_o; p.ie_db = ie_db_o; p.ie_dqs = ie_dqs_o;
    p.pd_db = pd_en_db_o; p.pd_dqs = pd_en_dqs_o;
    p.cmd_ready = cmd_ready_o; p.wdata_ready = wdata_ready_o; p.busy = busy_o;
    return p;
  endfunction

  task automatic drive(input stim_t s);
    cmd_valid_i   = s.cv;
    cmd_wr_i      = s.cw;
    cmd_len_i     = s.len;
    cmd_i         = s.cmd;
    wdata_valid_i = s.wv;
    wdata_i       = s.wd;
  endtask

  // Queue one whole transaction: stimulus per cycle and the pad state expected after that edge.
  // gap_at inserts gap_len idle cycles before that beat index; noise pokes ignored inputs.
  task automatic gen_txn(input logic [31:0] cmd, input logic wr, input int nbeats,
                         input logic [15:0] base, input int gap_at, input int gap_len,
                         input logic noise);
    stim_t s;
    logic c, d;
    logic [15:0] db;
    s = '0;
    s.cv = 1'b1; s.cw = wr; s.len = LW'(nbeats - 1); s.cmd = cmd;
    s.wv = noise; s.wd = 16'hBAD0;
    sq.push_back(s); eq.push_back(mk(1, 0, 0, 16'h0, 0, 0, 0, 0, 0, 1));
    s.cv = noise; s.cmd = ~cmd; s.cw = ~wr; s.len = ~s.len;
    sq.push_back(s); eq.push_back(mk(0, 0, 0, 16'h0, 0, 0, 0, 0, 0, 1));
    sq.push_back(s); eq.push_back(mk(0, 1, 1, cmd[31:16], 0, 1, 0, 0, 0, 1));
    sq.push_back(s); eq.push_back(mk(0, 1, 0, cmd[15:0], 0, 1, 0, 0, 0, 1));
    if (!wr) begin
      sq.push_back(s); eq.push_back(mk(1, 0, 0, 16'h0, 0, 0, 0, 1, 0, 0));
      return;
    end
    c = 1'b0; d = 1'b0; db = 16'h0;
    for (int p = 0; p < PRE; p++) begin
      c = ~c;
      sq.push_back(s); eq.push_back(mk(0, 0, c, 16'h0, 0, 1, 1, 0, (p == PRE - 1), 1));
    end
    for (int b = 0; b < nbeats; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          s.wv = 1'b0; s.wd = 16'hDEAD;
          sq.push_back(s); eq.push_back(mk(0, 0, c, db, d, 1, 1, 0, 1, 1));
        end
      end
      c = ~c; d = ~d; db = base + 16'(b) * 16'h1111;
      s.wv = 1'b1; s.wd = db;
      sq.push_back(s); eq.push_back(mk(0, 0, c, db, d, 1, 1, 0, (b != nbeats - 1), 1));
    end
    s.wv = noise; s.wd = 16'hBAD1;
    c = ~c;
    sq.push_back(s); eq.push_back(mk(0, 0, c, db, d, 1, 1, 0, 0, 1));
    sq.push_back(s); eq.push_back(mk(1, 0, 0, 16'h0, 0, 0, 0, 1, 0, 0));
  endtask

  task automatic test_reset();
    pins_t a, e;
    e = mk(1, 0, 0, 16'h0, 0, 0, 0, 1, 0, 0);
    drive('0);
    rst_ni = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    a = sample(); nchk++;
    if (a !== e) begin nerr++; $display("FAIL reset_async got=%h exp=%h", a, e); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      a = sample(); nchk++;
      if (a !== e) begin nerr++; $display("FAIL reset_hold cyc%0d got=%h exp=%h", k, a, e); end
    end
    rst_ni = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_i); #1;
      a = sample(); nchk++;
      if (a !== e) begin nerr++; $display("FAIL reset_idle cyc%0d got=%h exp=%h", k, a, e); end
    end
  endtask

  task automatic test_read();
    pins_t a, e;
    int k = 0;
    gen_txn(32'hDEADBEEF, 1'b0, 1, 16'h0, -1, 0, 1'b1);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk_i); #1;
      e = eq.pop_front(); a = sample(); nchk++;
      if (a !== e) begin nerr++; $display("FAIL read cyc%0d got=%h exp=%h", k, a, e); end
      k++;
    end
    drive('0);
  endtask

  task automatic test_write();
    pins_t a, e;
    int k = 0;
    gen_txn(32'hA0B1C2D3, 1'b1, 4, 16'h1111, -1, 0, 1'b1);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk_i); #1;
      e = eq.pop_front(); a = sample(); nchk++;
      if (a !== e) begin nerr++; $display("FAIL write cyc%0d got=%h exp=%h", k, a, e); end
      k++;
    end
    drive('0);
  endtask

  task automatic test_stall();
    pins_t a, e;
    int k = 0;
    gen_txn(32'h13572468, 1'b1, 4, 16'h1111, 2, 3, 1'b0);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk_i); #1;
      e = eq.pop_front(); a = sample(); nchk++;
      if (a !== e) begin nerr++; $display("FAIL stall cyc%0d got=%h exp=%h", k, a, e); end
      k++;
    end
    drive('0);
  endtask

  task automatic test_back_to_back();
    pins_t a, e;
    int k = 0;
    gen_txn(32'h01234567, 1'b0, 1, 16'h0, -1, 0, 1'b1);
    gen_txn(32'h89ABCDEF, 1'b0, 1, 16'h0, -1, 0, 1'b0);
    gen_txn(32'h55AA33CC, 1'b1, 1, 16'h7E7E, -1, 0, 1'b1);
    gen_txn(32'hFEDCBA98, 1'b0, 1, 16'h0, -1, 0, 1'b1);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk_i); #1;
      e = eq.pop_front(); a = sample(); nchk++;
      if (a !== e) begin nerr++; $display("FAIL b2b cyc%0d got=%h exp=%h", k, a, e); end
      k++;
    end
    drive('0);
  endtask

  task automatic test_max_len();
    pins_t a, e;
    int k = 0;
    gen_txn(32'hCAFE0001, 1'b1, 1 << LW, 16'h0001, 9, 2, 1'b1);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk_i); #1;
      e = eq.pop_front(); a = sample(); nchk++;
      if (a !== e) begin nerr++; $display("FAIL maxlen cyc%0d got=%h exp=%h", k, a, e); end
      k++;
    end
    drive('0);
  endtask

  task automatic test_reset_mid_burst();
    pins_t a, e;
    int k = 0;
    gen_txn(32'h0F0F0F0F, 1'b1, 4, 16'h1111, -1, 0, 1'b0);
    // Run through the first accepted beat (cmd, PRE, beat 0), then pull reset between edges.
    while (sq.size() > 0 && k < 4 + PRE + 1) begin
      drive(sq.pop_front());
      @(posedge clk_i); #1;
      e = eq.pop_front(); a = sample(); nchk++;
      if (a !== e) begin nerr++; $display("FAIL midrst_pre cyc%0d got=%h exp=%h", k, a, e); end
      k++;
    end
    sq.delete();
    eq.delete();
    #2 rst_ni = 1'b0;
    drive('0);
    #1;
    e = mk(1, 0, 0, 16'h0, 0, 0, 0, 1, 0, 0);
    a = sample(); nchk++;
    if (a !== e) begin nerr++; $display("FAIL midrst_async got=%h exp=%h", a, e); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    k = 0;
    gen_txn(32'h600DF00D, 1'b1, 1, 16'hA5A5, -1, 0, 1'b1);
    while (sq.size() > 0) begin
      drive(sq.pop_front());
      @(posedge clk_i); #1;
      e = eq.pop_front(); a = sample(); nchk++;
      if (a !== e) begin nerr++; $display("FAIL midrst_len0 cyc%0d got=%h exp=%h", k, a, e); end
      k++;
    end
    drive('0);
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_stall();
    test_back_to_back();
    test_max_len();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
